// File: rtl/uart_tx_scheduler.sv
// Arbitrates register-file bytes and two-byte ALU results onto a single UART
// transmitter, with one-entry pending buffers per source and a busy-rise timeout.
module uart_tx_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int HI_TIMEOUT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    RF_RD_VLD,
  input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
  input  logic                    ALU_OUT_VLD,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    TX_BUSY,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  output logic                    SCHED_BUSY,
  output logic [1:0]              OVERRUN,
  output logic                    TX_TIMEOUT
);

  localparam int CW = $clog2(HI_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} state_t;

  state_t                  state, next_state;
  logic                    rf_pend, alu_pend;
  logic [DATA_WIDTH-1:0]   rf_data;
  logic [2*DATA_WIDTH-1:0] alu_data;
  logic [DATA_WIDTH-1:0]   hi_byte;
  logic [DATA_WIDTH-1:0]   tx_data;
  logic                    byte_sel;
  logic                    last_alu;
  logic [CW-1:0]           tmo_cnt;
  logic [1:0]              overrun_q;
  logic                    timeout_q;

  logic grant_rf, grant_alu, load_hi, tmo_hit;

  always_comb begin
    next_state = state;
    grant_rf   = 1'b0;
    grant_alu  = 1'b0;
    load_hi    = 1'b0;
    tmo_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (!TX_BUSY && (rf_pend || alu_pend)) begin
          // Tie goes to whichever source was not served last
          if (rf_pend && alu_pend) begin
            grant_rf  = last_alu;
            grant_alu = !last_alu;
          end else begin
            grant_rf  = rf_pend;
            grant_alu = alu_pend;
          end
          next_state = ISSUE;
        end
      end
      ISSUE: next_state = WAIT_HI;
      WAIT_HI: begin
        if (TX_BUSY) begin
          next_state = WAIT_LO;
        end else if (tmo_cnt == CW'(HI_TIMEOUT - 1)) begin
          tmo_hit    = 1'b1;
          next_state = ISSUE;
        end
      end
      WAIT_LO: begin
        if (!TX_BUSY) begin
          if (byte_sel) begin
            load_hi    = 1'b1;
            next_state = ISSUE;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_pend   <= 1'b0;
      rf_data   <= '0;
      alu_pend  <= 1'b0;
      alu_data  <= '0;
      hi_byte   <= '0;
      tx_data   <= '0;
      byte_sel  <= 1'b0;
      last_alu  <= 1'b1;
      tmo_cnt   <= '0;
      overrun_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      overrun_q <= {ALU_OUT_VLD && alu_pend && !grant_alu,
                    RF_RD_VLD   && rf_pend  && !grant_rf};
      timeout_q <= tmo_hit;

      if (RF_RD_VLD && (!rf_pend || grant_rf)) begin
        rf_pend <= 1'b1;
        rf_data <= RF_RD_DATA;
      end else if (grant_rf) begin
        rf_pend <= 1'b0;
      end

      if (ALU_OUT_VLD && (!alu_pend || grant_alu)) begin
        alu_pend <= 1'b1;
        alu_data <= ALU_OUT;
      end else if (grant_alu) begin
        alu_pend <= 1'b0;
      end

      // High byte is snapshotted at grant so a newly captured ALU word cannot corrupt it
      if (grant_rf) begin
        tx_data  <= rf_data;
        byte_sel <= 1'b0;
        last_alu <= 1'b0;
      end else if (grant_alu) begin
        tx_data  <= alu_data[DATA_WIDTH-1:0];
        hi_byte  <= alu_data[2*DATA_WIDTH-1:DATA_WIDTH];
        byte_sel <= 1'b1;
        last_alu <= 1'b1;
      end else if (load_hi) begin
        tx_data  <= hi_byte;
        byte_sel <= 1'b0;
      end

      if (state == WAIT_HI && !TX_BUSY && !tmo_hit) tmo_cnt <= tmo_cnt + CW'(1);
      else                                          tmo_cnt <= '0;
    end
  end

  assign TX_P_DATA  = tx_data;
  assign TX_D_VLD   = (state == ISSUE);
  assign SCHED_BUSY = (state != IDLE) || rf_pend || alu_pend;
  assign OVERRUN    = overrun_q;
  assign TX_TIMEOUT = timeout_q;

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the UART transmit byte width.
REQ-002 SHALL have parameter HI_TIMEOUT, default 8, giving the maximum cycles to wait for TX_BUSY rise after an issue.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port RF_RD_VLD, input, 1 bit: one-cycle pulse marking RF_RD_DATA valid.
REQ-006 SHALL have port RF_RD_DATA, input, DATA_WIDTH bits: register-file read byte to transmit.
REQ-007 SHALL have port ALU_OUT_VLD, input, 1 bit: one-cycle pulse marking ALU_OUT valid.
REQ-008 SHALL have port ALU_OUT, input, 2*DATA_WIDTH bits: ALU result, transmitted as two bytes.
REQ-009 SHALL have port TX_BUSY, input, 1 bit: registered busy from the UART transmitter.
REQ-010 SHALL have port TX_P_DATA, output, DATA_WIDTH bits: parallel byte to the UART transmitter.
REQ-011 SHALL have port TX_D_VLD, output, 1 bit: one-cycle data-valid strobe to the UART transmitter.
REQ-012 SHALL have port SCHED_BUSY, output, 1 bit: high whenever the FSM is not IDLE or any pending flag is set.
REQ-013 SHALL have port OVERRUN, output, 2 bits: one-cycle pulse; bit0 for RF, bit1 for ALU request dropped.
REQ-014 SHALL have port TX_TIMEOUT, output, 1 bit: one-cycle pulse when TX_BUSY fails to rise within HI_TIMEOUT.

Function
REQ-015 SHALL capture each source into a one-entry pending register (flag plus data) on the edge ending the valid pulse.
REQ-016 SHALL drop a valid pulse arriving while that source's flag is set and not being granted, keep the old data, and pulse the matching OVERRUN bit the next cycle.
REQ-017 SHALL accept a valid pulse in the same cycle its source is granted into the pending register, with no OVERRUN.
REQ-018 SHALL implement the FSM states IDLE, ISSUE, WAIT_HI and WAIT_LO.
REQ-019 SHALL, in IDLE with TX_BUSY low and at least one flag set, grant a source, clear its flag, load the first byte into TX_P_DATA and go to ISSUE.
REQ-020 SHALL grant round-robin: when both flags are set, grant the source not granted last; last-grant resets to ALU, so RF wins the first tie.
REQ-021 SHALL send ALU results LSB byte first (ALU_OUT[7:0], then ALU_OUT[15:8]); RF grants send one byte.
REQ-022 SHALL drive TX_D_VLD high for exactly the single cycle spent in ISSUE, then go to WAIT_HI.
REQ-023 SHALL hold TX_P_DATA stable from the ISSUE load until the next load.
REQ-024 SHALL, in WAIT_HI, go to WAIT_LO when TX_BUSY is 1.
REQ-025 SHALL, in WAIT_HI after HI_TIMEOUT cycles without TX_BUSY, pulse TX_TIMEOUT and return to ISSUE to re-strobe the same byte.
REQ-026 SHALL, in WAIT_LO on TX_BUSY 0, load the ALU high byte and go to ISSUE if the ALU first byte is done, else go to IDLE.
REQ-027 SHALL NOT re-arbitrate between the two ALU bytes.
REQ-028 SHALL time the path as: RF_RD_VLD in cycle n, TX_D_VLD in cycle n+2 when idle and TX_BUSY is low.

Reset
REQ-029 SHALL, with rst low at a clk edge, force state IDLE, all pending flags 0, last-grant ALU, byte select 0 and the timeout counter 0.
REQ-030 SHALL, under reset, force TX_P_DATA 0, TX_D_VLD 0, SCHED_BUSY 0, OVERRUN 0 and TX_TIMEOUT 0.
REQ-031 SHALL, on reset mid-transfer, abandon any partially sent ALU word and any pending data with no output strobe.

Verification
REQ-032 SHALL cover: RF_RD_VLD with data 0xA5, TX model raising busy 2 cycles after strobe and holding 11 cycles -> TX_D_VLD one cycle at n+2, TX_P_DATA=0xA5, SCHED_BUSY low after busy falls.
REQ-033 SHALL cover: ALU_OUT_VLD with 0x1234 -> two strobes, 0x34 then 0x12, the second only after TX_BUSY falls.
REQ-034 SHALL cover: RF and ALU valid in the same cycle from reset -> RF byte first, then ALU 2 bytes; a repeat tie -> ALU first.
REQ-035 SHALL cover: a second RF_RD_VLD (0x22) while the first (0x11) is still pending -> OVERRUN=01 for one cycle, only 0x11 sent.
REQ-036 SHALL cover: TX_BUSY held 0 after a strobe -> TX_TIMEOUT pulse after 8 cycles, then a re-strobe of the same byte.
REQ-037 SHALL cover: rst low in WAIT_LO between ALU bytes -> all outputs 0 next cycle, no high-byte strobe after release.
